// File: rtl/wb_burst_sram.sv
// Wishbone B4 slave SRAM with registered-feedback incrementing bursts (linear / wrap-4/8/16).
// Define WB_SRAM_BURST_EN to build the burst engine; otherwise every access is classic single-cycle.
module wb_burst_sram #(
  parameter int              DW          = 32,
  parameter int              AW          = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [AW-1:0]   BASE_ADDR   = 32'h0001_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);
  localparam int            IW   = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] SPAN = AW'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic [IW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q;
  logic [DW-1:0]   mem [DEPTH_WORDS];

  logic            req, inr, ack_int;
  logic [AW-1:0]   off;
  logic [IW-1:0]   idx, rd_idx;
  logic            wr_en, rd_en, dat_clr;

  assign req = wb_cyc_i & wb_stb_i;
  assign off = wb_adr_i - BASE_ADDR;
  assign inr = off < SPAN;
  assign idx = off[IW+1:2];

`ifdef WB_SRAM_BURST_EN
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] w, input logic [1:0] bte);
    logic [IW-1:0] inc, m;
    inc = w + IW'(1);
    case (bte)
      2'b01:   m = IW'(3);
      2'b10:   m = IW'(7);
      2'b11:   m = IW'(15);
      default: m = '0;
    endcase
    return (bte == 2'b00) ? inc : ((w & ~m) | (inc & m));
  endfunction

  // In a burst the ack is speculative: it only counts while the master sits on the prefetched word.
  assign ack_int = ack_q & ((state_q != BURST) | (req & inr & (idx == adr_q)));
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{wb_cti_i, wb_bte_i};
  assign ack_int = ack_q;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    adr_d   = adr_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = idx;
    dat_clr = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        adr_d = idx;
        if (!inr) begin
          state_d = SINGLE;
          err_d   = 1'b1;
          dat_clr = 1'b1;
        end else begin
          rd_en = 1'b1;
          ack_d = 1'b1;
`ifdef WB_SRAM_BURST_EN
          state_d = (wb_cti_i == 3'b010) ? BURST : SINGLE;
`else
          state_d = SINGLE;
`endif
        end
      end
      SINGLE: begin
        state_d = IDLE;
        wr_en   = ack_q & req & wb_we_i;
      end
`ifdef WB_SRAM_BURST_EN
      BURST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (ack_int) begin
          wr_en = wb_we_i;
          if (wb_cti_i == 3'b010) begin
            adr_d  = next_idx(adr_q, wb_bte_i);
            rd_idx = next_idx(adr_q, wb_bte_i);
            rd_en  = 1'b1;
            ack_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (req && !inr) begin
          state_d = SINGLE;
          err_d   = 1'b1;
          dat_clr = 1'b1;
        end else if (req) begin
          // master jumped away from the prediction: re-read at its address, one bubble
          adr_d = idx;
          rd_en = 1'b1;
          ack_d = 1'b1;
        end else begin
          ack_d = ack_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en && !wb_rst_i) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_i[b]) mem[adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || dat_clr) begin
      dat_q <= '0;
    end else if (rd_en) begin
      for (int b = 0; b < 4; b++)
        dat_q[8*b +: 8] <= (wr_en && wb_sel_i[b] && (adr_q == rd_idx)) ?
                           wb_dat_i[8*b +: 8] : mem[rd_idx][8*b +: 8];
    end
  end

  assign wb_ack_o = ack_int;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_burst_sram.sv
// Randomized scoreboard bench for wb_burst_sram: a bus master pushes expected terminations,
// a negedge monitor pops and compares them; the memory model is a plain word array.
module tb_wb_burst_sram;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
`ifdef WB_SRAM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat_w = '0, dat_r;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        ack, err, rty;

  always #5 clk = ~clk;

  wb_burst_sram #(.DW(32), .AW(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_cti_i(cti),
    .wb_bte_i(bte), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty));

  typedef struct {logic is_err; logic chk; logic [31:0] dat;} exp_t;
  exp_t        q[$];
  logic [31:0] model [DEPTH];
  int          n_cmp = 0, n_bad = 0;
  logic        rst_edge = 1'b0;
  logic [31:0] beat_dat;
  int          bw[16];
  logic [31:0] bd[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_edge) begin
      check("reset_ack_err", {30'b0, ack, err}, 32'd0);
      check("reset_dat", dat_r, 32'd0);
    end else if (ack || err) begin
      if (q.size() == 0) begin
        check("unexpected_termination", {30'b0, ack, err}, 32'd0);
      end else begin
        e = q.pop_front();
        check("term_kind", {30'b0, ack, err}, e.is_err ? 32'd1 : 32'd2);
        if (e.chk) check("read_data", dat_r, e.dat);
      end
    end
  end

  // next word of a burst: step within an aligned block of the burst length (whole memory = linear)
  function automatic int nw(input int w, input logic [1:0] b);
    int n, base;
    case (b)
      2'b01:   n = 4;
      2'b10:   n = 8;
      2'b11:   n = 16;
      default: n = DEPTH;
    endcase
    base = w - (w % n);
    return base + ((w + 1 - base) % n);
  endfunction

  task automatic idle(input int n);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [31:0] a, input bit w_en, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                      output int waits);
    logic [31:0] off;
    bit inr, done;
    int w;
    exp_t e;
    off = a - BASE;
    inr = off < SPAN;
    w = int'(off >> 2);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w_en; dat_w = d; sel = s; cti = c; bte = b;
    e.is_err = !inr;
    e.chk = !inr || !w_en;
    e.dat = '0;
    if (inr && !w_en) e.dat = model[w];
    q.push_back(e);
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ack || err) begin
        done = 1'b1;
        beat_dat = dat_r;
      end else begin
        waits++;
        if (waits > 40) begin
          check("beat_timeout", 32'(waits), 32'd0);
          q.delete();
          return;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    if (inr && w_en)
      for (int i = 0; i < 4; i++) if (s[i]) model[w][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic burst(input int start, input int len, input logic [1:0] b, input bit w_en,
                       input logic [3:0] s, input bit rnd, input int jump_at, input int jump_w);
    int w, wt;
    logic [31:0] d;
    w = start;
    for (int k = 0; k < len; k++) begin
      if (k == jump_at) w = jump_w;
      d = rnd ? $urandom : 32'(k);
      beat(BASE + 32'(w * 4), w_en, d, s, (k == len - 1) ? 3'b111 : 3'b010, b, wt);
      if (k < 16) begin bw[k] = wt; bd[k] = beat_dat; end
      w = nw(w, b);
    end
    idle(1);
  endtask

  function automatic int exp_wait(input int k, input bit bubble);
    return (!BURST_EN || k == 0 || bubble) ? 1 : 0;
  endfunction

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int wt, wts[3];
    logic [31:0] d0, d1, d2, old2;
    // reset held with a live request on the bus: outputs must stay quiet
    repeat (2) @(posedge clk);
    #1; cyc = 1'b1; stb = 1'b1; adr = BASE;
    repeat (3) @(posedge clk);
    #1; idle(1);
    rst = 1'b0;

    burst(0, DEPTH, 2'b00, 1'b1, 4'hF, 1'b1, -1, 0);

    // classic byte-lane write then read
    beat(BASE + 32'h10, 1'b1, 32'h0, 4'hF, 3'b000, 2'b00, wt);
    beat(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'b0101, 3'b000, 2'b00, wt);
    check("classic_wr_wait", 32'(wt), 32'd1);
    beat(BASE + 32'h10, 1'b0, $urandom, 4'b0000, 3'b000, 2'b00, wt);
    check("classic_rd_wait", 32'(wt), 32'd1);
    check("classic_rd_data", beat_dat, 32'h00AD_00EF);
    @(negedge clk);
    check("classic_ack_one_cycle", {30'b0, ack, err}, 32'd0);
    idle(1);

    // wrap-4 read burst from word 2
    burst(0, 4, 2'b00, 1'b1, 4'hF, 1'b0, -1, 0);
    burst(2, 4, 2'b01, 1'b0, 4'hF, 1'b0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap4_wait%0d", k), 32'(bw[k]), 32'(exp_wait(k, 1'b0)));
      check($sformatf("wrap4_data%0d", k), bd[k], 32'((k + 2) % 4));
    end

    // linear burst, master jumps to word 0x10 on beat 3
    burst(0, 6, 2'b00, 1'b0, 4'hF, 1'b0, 3, 16);
    for (int k = 0; k < 6; k++)
      check($sformatf("jump_wait%0d", k), 32'(bw[k]), 32'(exp_wait(k, k == 3)));
    check("jump_data", bd[3], model[16]);

    // out-of-range accesses
    beat(BASE + SPAN, 1'b0, '0, 4'hF, 3'b000, 2'b00, wt);
    check("oor_rd_wait", 32'(wt), 32'd1);
    @(negedge clk);
    check("oor_err_one_cycle", {30'b0, ack, err}, 32'd0);
    idle(1);
    beat(BASE + SPAN + 32'h10, 1'b1, $urandom, 4'hF, 3'b000, 2'b00, wt);
    beat(BASE - 32'd4, 1'b1, $urandom, 4'hF, 3'b010, 2'b00, wt);
    idle(1);
    beat(BASE + 32'h10, 1'b0, '0, 4'hF, 3'b000, 2'b00, wt);
    check("oor_mem_unchanged", beat_dat, 32'h00AD_00EF);
    idle(1);

    // reset on beat 2 of a 4-beat write burst
    d0 = $urandom; d1 = $urandom; d2 = ~model[34]; old2 = model[34];
    beat(BASE + 32'h80, 1'b1, d0, 4'hF, 3'b010, 2'b00, wts[0]);
    beat(BASE + 32'h84, 1'b1, d1, 4'hF, 3'b010, 2'b00, wts[1]);
    begin : beat2
      exp_t e;
      e.is_err = 1'b0; e.chk = 1'b0; e.dat = '0;
      adr = BASE + 32'h88; dat_w = d2; cti = 3'b010;
      q.push_back(e);
      wts[2] = 0;
      forever begin
        @(negedge clk);
        if (ack || err) break;
        wts[2]++;
        if (wts[2] > 40) begin
          check("rst_beat_timeout", 32'(wts[2]), 32'd0);
          q.delete();
          break;
        end
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      check($sformatf("rst_burst_wait%0d", k), 32'(wts[k]), 32'(exp_wait(k, 1'b0)));
    beat(BASE + 32'h80, 1'b0, '0, 4'hF, 3'b000, 2'b00, wt);
    check("rst_beat0_kept", beat_dat, d0);
    beat(BASE + 32'h84, 1'b0, '0, 4'hF, 3'b000, 2'b00, wt);
    check("rst_beat1_kept", beat_dat, d1);
    beat(BASE + 32'h88, 1'b0, '0, 4'hF, 3'b000, 2'b00, wt);
    check("rst_beat2_dropped", beat_dat, old2);
    idle(1);

    // random mix of classic accesses and bursts
    for (int t = 0; t < 150; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        burst($urandom_range(0, DEPTH - 1), $urandom_range(2, 8), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom), 1'b1, -1, 0);
      end else begin
        logic [31:0] a;
        a = (r == 9) ? BASE + SPAN + 32'($urandom_range(0, 255) * 4)
                     : BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        a = a + 32'($urandom_range(0, 3));
        beat(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             (r < 6) ? 3'b000 : ((r < 8) ? 3'b111 : 3'b011), 2'($urandom_range(0, 3)), wt);
        idle($urandom_range(0, 2));
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("rty_low", {31'b0, rty}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_burst_sram.md
# wb_burst_sram

Wishbone B4 slave on-chip SRAM. It answers the CPU's instruction and data cache refills on the shared intercon, including registered-feedback incrementing bursts with linear or wrapped addressing. It occupies one slave slot of `intercon` and is clocked and reset alongside the other peripherals.

## Interface
Parameters:
- `DW`, 32, data width (must be 32).
- `AW`, 32, address width.
- `DEPTH_WORDS`, 1024, memory depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0001_0000, byte base address; aligned to DEPTH_WORDS*4.

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i`  in  1  clock; all logic on its rising edge.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `wb_adr_i`  in  AW  byte address; bits [1:0] ignored.
- `wb_dat_i`  in  DW  write data.
- `wb_dat_o`  out  DW  read data; valid while `wb_ack_o`=1.
- `wb_sel_i`  in  4  byte lane enables; bit n enables lane [8n+7:8n].
- `wb_we_i`  in  1  1=write.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst; other values are treated as 000.
- `wb_bte_i`  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `wb_rty_o`  out  1  tied to 0.

## Operation
- Request = `wb_cyc_i & wb_stb_i`.
- Word index = (`wb_adr_i` − BASE_ADDR) >> 2.
- Out of range: the offset is ≥ DEPTH_WORDS*4. The slave then pulses `wb_err_o` instead of `wb_ack_o`, performs no write, and drives `wb_dat_o`=0.
- Memory is a single-port synchronous RAM with one-cycle read latency. Writes apply only the lanes enabled by `wb_sel_i`, on the cycle `wb_ack_o` is asserted. Reads ignore `wb_sel_i`.
- FSM states:
  - IDLE: on a request with cti≠010 → SINGLE. On a request with cti=010 → BURST.
  - SINGLE: asserts ack/err for exactly one cycle, then → IDLE.
  - BURST: asserts ack every cycle while the request holds and the address matches the predicted next address (`nxt_adr`).
    - cti=111 on an acked beat → IDLE after that beat.
    - Request dropped (stb=0 or cyc=0) → hold in BURST with ack=0. If cyc=0 → IDLE.
    - Address mismatch → ack=0 for one cycle while the RAM re-reads; the burst then resumes from the new address.
    - An out-of-range beat → err, then → IDLE.
- Next-address rule, on word index w:
  - linear: w+1, wrapping modulo DEPTH_WORDS.
  - wrap-N: (w & ~(N−1)) | ((w+1) & (N−1)).
  - The prefetch read is issued at `nxt_adr` each acked beat.
- `wb_rty_o` is constantly 0.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, FSM=IDLE. Memory contents are not cleared.
- Classic access: request sampled at edge N → ack/err high in cycle N+1 → low in N+2, even if stb stays high. Minimum classic spacing is 2 cycles.
- Burst: first ack at N+1, then one beat per cycle. A 4-beat burst completes in 5 cycles from first strobe.
- A write beat followed by a read of the same word in a burst returns the newly written data (write-first bypass).
- Reset asserted mid-burst: ack/err are 0 from the next edge and the FSM is IDLE. Any write pending on that edge is discarded.
- `cyc_i` deasserted in any state: ack=0 from the next edge, → IDLE.

## Configuration
- `WB_SRAM_BURST_EN` defined: BURST state, the prefetch logic and the bte wrapping are compiled in.
- `WB_SRAM_BURST_EN` undefined: cti and bte are ignored. Every request is handled as SINGLE (2 cycles per beat), the BURST logic is absent, and the behaviour is Wishbone-classic compliant.

## Test plan
- Reset → `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0 for every cycle while `wb_rst_i`=1.
- Classic write 32'hDEAD_BEEF to BASE+0x10 with sel=4'b0101, after the word was 0 → a classic read returns 32'h00AD_00EF. Ack lasts 1 cycle, 2 cycles per access.
- Wrap-4 read burst (bte=01, cti=010, final beat 111) starting at BASE+0x08, words 0..3 preloaded with 0..3 → data 2,3,0,1 on consecutive cycles with ack held high for 4 cycles.
- Linear burst with the master changing the address to BASE+0x40 on beat 3 → one ack=0 bubble, then the data of word 0x10 is returned.
- Access to BASE+DEPTH_WORDS*4 → single `wb_err_o` pulse, no ack, and a later read shows memory unchanged.
- Reset asserted on beat 2 of a 4-beat write burst → beats 0–1 stored, beat 2 not written, ack=0 the next cycle. With `WB_SRAM_BURST_EN` undefined, the same stimulus yields ack on alternate cycles only.
